// File: rtl/mmio_port_arbiter_if.sv
// rtl/mmio_port_arbiter_if.sv - offer/accept bus between the port arbiter and the shared peripheral
interface mmio_port_arbiter_if #(
  parameter int PORT_EXPONENT = 3
) ();
  logic                     dev_valid;
  logic                     dev_ready;
  logic [PORT_EXPONENT-1:0] dev_port;
  logic [31:0]              dev_data;

  modport master (
    output dev_valid,
    output dev_port,
    output dev_data,
    input  dev_ready
  );

  modport slave (
    input  dev_valid,
    input  dev_port,
    input  dev_data,
    output dev_ready
  );
endinterface

// File: rtl/mmio_port_arbiter.sv
// rtl/mmio_port_arbiter.sv - latches MMIO port writes and round-robin offers them on one peripheral bus
module mmio_port_arbiter #(
  parameter  int PORT_EXPONENT = 3,
  localparam int PORT_COUNT    = 2 ** PORT_EXPONENT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORT_COUNT-1:0] port_write_evt_i,
  input  logic [15:0]           port_data_i [2*PORT_COUNT],
  mmio_port_arbiter_if.master   dev,
  output logic [PORT_COUNT-1:0] pending_o,
  output logic [PORT_COUNT-1:0] overrun_o,
  input  logic [PORT_COUNT-1:0] overrun_clr_i
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_e;

  state_e                   state_q, state_d;
  logic [PORT_COUNT-1:0]    pending_q, pending_d;
  logic [PORT_COUNT-1:0]    overrun_q, overrun_d;
  logic                     requeue_q, requeue_d;
  logic [PORT_EXPONENT-1:0] last_grant_q, last_grant_d;
  logic [PORT_EXPONENT-1:0] grant_q, grant_d;
  logic [31:0]              dev_data_q, dev_data_d;
  logic [31:0]              holding_q [PORT_COUNT];
  logic [31:0]              holding_d [PORT_COUNT];

  logic [PORT_EXPONENT-1:0] rr_idx;
  logic [PORT_EXPONENT-1:0] rr_grant;
  logic                     rr_found;

  // Search starts just after the last served port; the index width makes the wrap implicit.
  always_comb begin
    rr_idx   = '0;
    rr_grant = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= PORT_COUNT; i++) begin
      rr_idx = last_grant_q + PORT_EXPONENT'(i);
      if (!rr_found && pending_q[rr_idx]) begin
        rr_grant = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q & ~overrun_clr_i;
    requeue_d    = requeue_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    dev_data_d   = dev_data_q;
    for (int k = 0; k < PORT_COUNT; k++) begin
      holding_d[k] = holding_q[k];
    end

    // A write to the port currently on offer is queued for re-offer instead of counting as an overrun.
    for (int k = 0; k < PORT_COUNT; k++) begin
      if (port_write_evt_i[k]) begin
        holding_d[k] = {port_data_i[2*k+1], port_data_i[2*k]};
        if (state_q == OFFER && grant_q == PORT_EXPONENT'(k)) begin
          if (requeue_q) begin
            overrun_d[k] = 1'b1;
          end
          requeue_d = 1'b1;
        end else begin
          if (pending_q[k]) begin
            overrun_d[k] = 1'b1;
          end
          pending_d[k] = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d    = rr_grant;
          dev_data_d = holding_d[rr_grant];
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (dev.dev_ready) begin
          last_grant_d = grant_q;
          if (!requeue_d) begin
            pending_d[grant_q] = 1'b0;
          end
          requeue_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      overrun_q    <= '0;
      requeue_q    <= 1'b0;
      last_grant_q <= PORT_EXPONENT'(PORT_COUNT - 1);
      grant_q      <= '0;
      dev_data_q   <= '0;
      for (int k = 0; k < PORT_COUNT; k++) begin
        holding_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      requeue_q    <= requeue_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      dev_data_q   <= dev_data_d;
      for (int k = 0; k < PORT_COUNT; k++) begin
        holding_q[k] <= holding_d[k];
      end
    end
  end

  assign dev.dev_valid = (state_q == OFFER);
  assign dev.dev_port  = grant_q;
  assign dev.dev_data  = dev_data_q;
  assign pending_o     = pending_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_mmio_port_arbiter.sv
// tb/tb_mmio_port_arbiter.sv - scoreboard bench for mmio_port_arbiter
module tb_mmio_port_arbiter;
  localparam int PE = 3;
  localparam int PC = 8;

  logic          clk;
  logic          rst;
  logic [PC-1:0] evt;
  logic [15:0]   port_data [2*PC];
  logic [PC-1:0] pending;
  logic [PC-1:0] overrun;
  logic [PC-1:0] overrun_clr;

  mmio_port_arbiter_if #(.PORT_EXPONENT(PE)) dif ();

  mmio_port_arbiter #(.PORT_EXPONENT(PE)) dut (
    .clk              (clk),
    .rst              (rst),
    .port_write_evt_i (evt),
    .port_data_i      (port_data),
    .dev              (dif),
    .pending_o        (pending),
    .overrun_o        (overrun),
    .overrun_clr_i    (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [PE+31:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic [31:0] v);
    port_data[2*k]   = v[15:0];
    port_data[2*k+1] = v[31:16];
  endtask

  task automatic expect_offer(input int k, input logic [31:0] v);
    sb.push_back({PE'(k), v});
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (pending == '0 && !dif.dev_valid) done = 1;
    end
    chk("idle_timeout", {63'd0, done}, 64'd1);
  endtask

  // Monitor: every accepted offer must match the oldest expected delivery.
  always @(negedge clk) begin
    if (!rst && dif.dev_valid && dif.dev_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got port %0d data %0h expected no offer", dif.dev_port, dif.dev_data);
      end else begin
        logic [PE+31:0] e;
        e = sb.pop_front();
        chk("offer_port", {61'd0, dif.dev_port}, {61'd0, e[PE+31:32]});
        chk("offer_data", {32'd0, dif.dev_data}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    rst = 1'b1;
    evt = '0;
    overrun_clr = '0;
    dif.dev_ready = 1'b0;
    for (int i = 0; i < 2*PC; i++) port_data[i] = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_valid",   {63'd0, dif.dev_valid}, 64'd0);
    chk("rst_pending", {56'd0, pending}, 64'd0);
    chk("rst_overrun", {56'd0, overrun}, 64'd0);
    chk("rst_data",    {32'd0, dif.dev_data}, 64'd0);

    // Single event on port 3, minimum latency
    dif.dev_ready = 1'b1;
    port_data[6] = 16'h1234;
    port_data[7] = 16'hABCD;
    evt = 8'h08;
    expect_offer(3, 32'hABCD1234);
    tick();
    evt = '0;
    chk("t1_pending", {56'd0, pending}, 64'h08);
    chk("t1_valid_e0", {63'd0, dif.dev_valid}, 64'd0);
    tick();
    chk("t1_valid_e1", {63'd0, dif.dev_valid}, 64'd1);
    tick();
    chk("t1_pending_after", {56'd0, pending}, 64'd0);
    chk("t1_valid_after", {63'd0, dif.dev_valid}, 64'd0);

    // Fresh reset so port 0 has first priority, then ports 1,5,6 together
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_port(1, 32'h1111_0001);
    set_port(5, 32'h5555_0005);
    set_port(6, 32'h6666_0006);
    evt = 8'b0110_0010;
    expect_offer(1, 32'h1111_0001);
    expect_offer(5, 32'h5555_0005);
    expect_offer(6, 32'h6666_0006);
    tick();
    evt = '0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t2_valid_cadence", {63'd0, dif.dev_valid}, {63'd0, 1'(i % 2)});
    end
    chk("t2_overrun", {56'd0, overrun}, 64'd0);

    // Wrap: last grant 6, so 7 goes before 2
    set_port(2, 32'h2222_0002);
    set_port(7, 32'h7777_0007);
    evt = 8'h84;
    expect_offer(7, 32'h7777_0007);
    expect_offer(2, 32'h2222_0002);
    tick();
    evt = '0;
    wait_idle();

    // Port 4 rewritten while pending behind a stalled offer of port 3
    dif.dev_ready = 1'b0;
    set_port(3, 32'h3333_0003);
    evt = 8'h08;
    tick();
    evt = '0;
    tick();
    chk("t4_port3", {61'd0, dif.dev_port}, 64'd3);
    set_port(4, 32'h0000_0001);
    evt = 8'h10;
    tick();
    evt = '0;
    chk("t4_pending", {56'd0, pending}, 64'h18);
    chk("t4_no_overrun", {56'd0, overrun}, 64'd0);
    set_port(4, 32'h0000_0002);
    evt = 8'h10;
    tick();
    evt = '0;
    chk("t4_overrun", {56'd0, overrun}, 64'h10);
    expect_offer(3, 32'h3333_0003);
    expect_offer(4, 32'h0000_0002);
    dif.dev_ready = 1'b1;
    wait_idle();
    chk("t4_overrun_sticky", {56'd0, overrun}, 64'h10);
    overrun_clr = 8'h10;
    tick();
    overrun_clr = '0;
    chk("t4_overrun_clr", {56'd0, overrun}, 64'd0);

    // Rewrite of the offered port 0 mid-offer: data held, then re-offered
    dif.dev_ready = 1'b0;
    set_port(0, 32'h0000_0011);
    evt = 8'h01;
    tick();
    evt = '0;
    tick();
    chk("t5_valid", {63'd0, dif.dev_valid}, 64'd1);
    chk("t5_data_first", {32'd0, dif.dev_data}, 64'h11);
    tick();
    set_port(0, 32'h0000_0022);
    evt = 8'h01;
    tick();
    evt = '0;
    tick();
    tick();
    chk("t5_data_held", {32'd0, dif.dev_data}, 64'h11);
    chk("t5_pending", {56'd0, pending}, 64'h01);
    expect_offer(0, 32'h0000_0011);
    expect_offer(0, 32'h0000_0022);
    dif.dev_ready = 1'b1;
    wait_idle();
    chk("t5_overrun", {56'd0, overrun}, 64'd0);

    // Reset during an offer of port 2 with an overrun on port 5
    dif.dev_ready = 1'b0;
    set_port(2, 32'h2222_0202);
    evt = 8'h04;
    tick();
    evt = '0;
    tick();
    set_port(5, 32'h0000_0005);
    evt = 8'h20;
    tick();
    evt = '0;
    evt = 8'h20;
    tick();
    evt = '0;
    chk("t6_port2", {61'd0, dif.dev_port}, 64'd2);
    chk("t6_overrun_pre", {56'd0, overrun}, 64'h20);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {63'd0, dif.dev_valid}, 64'd0);
    chk("t6_rst_pending", {56'd0, pending}, 64'd0);
    chk("t6_rst_overrun", {56'd0, overrun}, 64'd0);
    tick();
    rst = 1'b0;
    dif.dev_ready = 1'b1;
    set_port(0, 32'h0000_0A0A);
    set_port(7, 32'h7070_0707);
    evt = 8'h81;
    expect_offer(0, 32'h0000_0A0A);
    expect_offer(7, 32'h7070_0707);
    tick();
    evt = '0;
    wait_idle();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
